sm83_dbg_brk: RTL

Parametrised hardware breakpoint and watchpoint unit for the SM83 debug path. It sits beside the CPU and the debug interface and snoops the CPU address bus and read/write strobes. It asserts `halt` when an enabled comparator matches and is programmed over the toggle-sequenced `data_rx`/`data_tx` byte channel. It generalises the single fixed halt/probe path to `NUM_BP` independently configured comparators, with status readback and resume masking.

---
 rtl/sm83_dbg_brk.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sm83_dbg_brk.sv
// sm83_dbg_brk: NUM_BP-way breakpoint unit programmed over a toggle byte channel; define SM83_DBG_BRK_WATCH_EN for write watchpoints
module sm83_dbg_brk #(
  parameter int NUM_BP = 4,
  parameter int ADR_W  = 16
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] adr,
  input  logic        p_rd,
  input  logic        p_wr,
  input  logic        ncyc,
  input  logic [7:0]  data_rx,
  input  logic        data_rx_valid,
  input  logic        data_rx_seq,
  output logic        data_rx_ack,
  output logic [7:0]  data_tx,
  output logic        data_tx_seq,
  input  logic        data_tx_ack,
  output logic        halt,
  output logic        hit,
  output logic [3:0]  hit_idx
);
  typedef enum logic [1:0] {IDLE, ARG, EXEC, RESP} state_e;
  state_e state_q, state_d;
  logic [7:0] op_q, op_d, resp_q, resp_d, tx_q, tx_d;
  logic [7:0] arg_q [4];
  logic [7:0] arg_d [4];
  logic [1:0] pos_q, pos_d;
  logic rx_ack_q, rx_ack_d, tx_seq_q, tx_seq_d;
  logic halt_q, halt_d, hit_q, hit_d, mask_q, mask_d;
  logic [3:0] idx_q, idx_d, m_idx;
  logic [ADR_W-1:0] bp_adr_q [NUM_BP];
  logic [NUM_BP-1:0] bp_en_q, bp_rd_q, wr_hit;
  logic acc, exec, idx_ok, err, do_set, do_clr, do_resume, do_halt, m_any;
  logic [15:0] set_adr;
  logic unused_w;
  assign acc = data_rx_valid && (data_rx_seq != rx_ack_q) && (state_q == IDLE || state_q == ARG);
  assign exec = state_q == EXEC;
  assign idx_ok = int'(arg_q[0]) < NUM_BP;
  assign err = (op_q == 8'h01 || op_q == 8'h02) ? !idx_ok : (op_q == 8'h00 || op_q > 8'h05);
  assign do_set = exec && op_q == 8'h01 && idx_ok;
  assign do_clr = exec && op_q == 8'h02 && idx_ok;
  assign do_resume = exec && op_q == 8'h04;
  assign do_halt = exec && op_q == 8'h05;
  assign set_adr = {arg_q[2], arg_q[1]};
  assign unused_w = ^{p_wr, arg_q[3], adr};
`ifdef SM83_DBG_BRK_WATCH_EN
  logic [NUM_BP-1:0] bp_wr_q;
  assign wr_hit = bp_wr_q & {NUM_BP{p_wr}};
  // write-enable mode bit per comparator
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) bp_wr_q <= '0;
    else
      for (int i = 0; i < NUM_BP; i++)
        if ((do_set || do_clr) && i == int'(arg_q[0])) bp_wr_q[i] <= do_set & arg_q[3][1];
  end
`else
  assign wr_hit = '0;
`endif
  // lowest-index comparator matching the current bus access
  always_comb begin
    m_any = 1'b0;
    m_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--)
      if (bp_en_q[i] && bp_adr_q[i] == adr[ADR_W-1:0] && ((bp_rd_q[i] && p_rd) || wr_hit[i])) begin
        m_any = 1'b1;
        m_idx = 4'(i);
      end
  end
  // comparator address and read/enable storage; a SET lands after the match of its own cycle
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NUM_BP; i++) bp_adr_q[i] <= '0;
      bp_en_q <= '0;
      bp_rd_q <= '0;
    end else
      for (int i = 0; i < NUM_BP; i++)
        if ((do_set || do_clr) && i == int'(arg_q[0])) begin
          bp_adr_q[i] <= do_set ? set_adr[ADR_W-1:0] : '0;
          bp_en_q[i] <= do_set & arg_q[3][2];
          bp_rd_q[i] <= do_set & arg_q[3][0];
        end
  end
  // command parser, reply channel and halt/hit bookkeeping
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    arg_d = arg_q;
    pos_d = pos_q;
    resp_d = resp_q;
    tx_d = tx_q;
    tx_seq_d = tx_seq_q;
    rx_ack_d = acc ? data_rx_seq : rx_ack_q;
    halt_d = halt_q;
    hit_d = hit_q;
    idx_d = idx_q;
    mask_d = ncyc ? 1'b0 : (mask_q | do_resume);
    case (state_q)
      IDLE:
        if (acc) begin
          op_d = data_rx;
          pos_d = '0;
          state_d = (data_rx == 8'h01 || data_rx == 8'h02) ? ARG : EXEC;
        end
      ARG:
        if (acc) begin
          arg_d[pos_q] = data_rx;
          pos_d = pos_q + 2'd1;
          if (pos_q == (op_q == 8'h01 ? 2'd3 : 2'd0)) state_d = EXEC;
        end
      EXEC: begin
        resp_d = op_q == 8'h03 ? {halt_q, hit_q, 2'b00, idx_q} : 8'hEE;
        state_d = (op_q == 8'h03 || err) ? RESP : IDLE;
      end
      default:
        if (data_tx_ack == tx_seq_q) begin
          tx_d = resp_q;
          tx_seq_d = ~tx_seq_q;
          state_d = IDLE;
        end
    endcase
    if (do_resume) begin
      halt_d = 1'b0;
      hit_d = 1'b0;
    end
    if (do_halt) begin
      halt_d = 1'b1;
      hit_d = 1'b0;
    end
    // a RESUME in the same cycle masks that strobe and uses up the mask
    if (ncyc && m_any && !halt_q && !mask_q && !do_resume) begin
      halt_d = 1'b1;
      hit_d = 1'b1;
      idx_d = m_idx;
    end
  end
  // state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      op_q <= '0;
      for (int i = 0; i < 4; i++) arg_q[i] <= '0;
      pos_q <= '0;
      resp_q <= '0;
      tx_q <= '0;
      tx_seq_q <= 1'b0;
      rx_ack_q <= 1'b0;
      halt_q <= 1'b0;
      hit_q <= 1'b0;
      idx_q <= '0;
      mask_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      arg_q <= arg_d;
      pos_q <= pos_d;
      resp_q <= resp_d;
      tx_q <= tx_d;
      tx_seq_q <= tx_seq_d;
      rx_ack_q <= rx_ack_d;
      halt_q <= halt_d;
      hit_q <= hit_d;
      idx_q <= idx_d;
      mask_q <= mask_d;
    end
  end
  assign data_rx_ack = rx_ack_q;
  assign data_tx = tx_q;
  assign data_tx_seq = tx_seq_q;
  assign halt = halt_q;
  assign hit = hit_q;
  assign hit_idx = idx_q;
endmodule
